// File: rtl/rv32_csr_sequencer_pkg.sv
// Shared CSR definitions: operation and sequencer state enums, CSR addresses,
// the write-request bundle, and the table of implemented CSR ids.
package rv32_csr_sequencer_pkg;

  localparam int NUM_IMPL_CSRS = 10;

  // mstatus bit positions
  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

  typedef enum logic [1:0] {
    CSR_RW = 2'd0,
    CSR_RS = 2'd1,
    CSR_RC = 2'd2
  } csr_op_t;

  typedef enum logic [3:0] {
    IDLE,
    EXEC,
    RESP,
    T_MEPC,
    T_MCAUSE,
    T_MSTATUS,
    T_VEC,
    M_MSTATUS,
    M_VEC
  } csr_seq_state_t;

  // CSR addresses shared by the bank and the sequencer
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef struct packed {
    logic        write;
    logic [11:0] id;
    logic [31:0] value;
  } csr_write_request_t;

  typedef struct packed {
    logic mie;
    logic mpie;
  } mstatus_t;

  // Every id the bank implements; anything else is an illegal access
  localparam logic [NUM_IMPL_CSRS-1:0][11:0] LEGAL_CSR_IDS = {
    CSR_MINSTRETH, CSR_MCYCLEH, CSR_MINSTRET, CSR_MCYCLE, CSR_MCAUSE,
    CSR_MEPC, CSR_MSCRATCH, CSR_MTVEC, CSR_MIE, CSR_MSTATUS
  };

  function automatic logic csr_is_legal(input logic [11:0] id);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_IMPL_CSRS; i++) begin
      if (LEGAL_CSR_IDS[i] == id) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/rv32_csr_alu.sv
// Read-modify-write datapath for CSR instructions: computes the new value,
// whether the write really happens, and whether the access is illegal.
module rv32_csr_alu
  import rv32_csr_sequencer_pkg::*;
(
  input  csr_op_t     op,
  input  logic [11:0] id,
  input  logic [31:0] old_value,
  input  logic [31:0] operand,
  input  logic        src_zero,
  output logic [31:0] new_value,
  output logic        write_en,
  output logic        illegal
);

  logic write_attempt;

  // CSRRS/CSRRC with a zero source are pure reads; CSRRW always writes
  assign write_attempt = (op == CSR_RW) || !src_zero;

  // Unknown id, or a write aimed at the read-only address quadrant
  assign illegal  = !csr_is_legal(id) || (write_attempt && (id[11:10] == 2'b11));
  assign write_en = write_attempt && !illegal;

  // Select the modified value for the requested operation
  always_comb begin
    new_value = operand;
    case (op)
      CSR_RW:  new_value = operand;
      CSR_RS:  new_value = old_value | operand;
      CSR_RC:  new_value = old_value & ~operand;
      default: new_value = operand;
    endcase
  end

endmodule

// File: rtl/rv32_csr_sequencer.sv
// CSR bank initiator: runs CSR instructions as read-modify-write accesses and
// serialises trap entry / MRET into one-write-per-cycle sequences ending with
// a fetch redirect.
module rv32_csr_sequencer
  import rv32_csr_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  csr_op_t            req_op,
  input  logic [11:0]        req_csr_id,
  input  logic [31:0]        req_operand,
  input  logic               req_src_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_illegal,
  input  logic               trap_valid,
  output logic               trap_ready,
  input  logic [31:0]        trap_cause,
  input  logic [31:0]        trap_pc,
  input  logic               mret_valid,
  output logic               mret_ready,
  output logic [11:0]        csr_read_id,
  input  logic [31:0]        csr_read_value,
  output csr_write_request_t csr_write_request,
  input  mstatus_t           mstatus,
  output logic               redirect_valid,
  output logic [31:0]        redirect_pc
);

  csr_seq_state_t state, state_next;

  csr_op_t     op_q;
  logic [11:0] id_q;
  logic [31:0] operand_q;
  logic        src_zero_q;
  logic [31:0] cause_q;
  logic [31:0] pc_q;
  logic [31:0] old_q;
  logic        illegal_q;

  logic [31:0] alu_new;
  logic        alu_we;
  logic        alu_ill;
  logic        idle;
  logic        unused_pc_lsb;

  // mepc is always word aligned, so the low PC bits never reach the bank
  assign unused_pc_lsb = ^pc_q[1:0];

  // Trap wins over MRET, MRET wins over an instruction; nothing is accepted in reset
  assign idle       = (state == IDLE) && !reset;
  assign trap_ready = idle;
  assign mret_ready = idle && !trap_valid;
  assign req_ready  = idle && !trap_valid && !mret_valid;

  rv32_csr_alu u_alu (
    .op        (op_q),
    .id        (id_q),
    .old_value (csr_read_value),
    .operand   (operand_q),
    .src_zero  (src_zero_q),
    .new_value (alu_new),
    .write_en  (alu_we),
    .illegal   (alu_ill)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Latch request fields at acceptance and the old CSR value during EXEC
  always_ff @(posedge clk) begin
    if (trap_valid && trap_ready) begin
      cause_q <= trap_cause;
      pc_q    <= trap_pc;
    end
    if (req_valid && req_ready) begin
      op_q       <= req_op;
      id_q       <= req_csr_id;
      operand_q  <= req_operand;
      src_zero_q <= req_src_zero;
    end
    if (state == EXEC) begin
      old_q     <= alu_ill ? 32'h0 : csr_read_value;
      illegal_q <= alu_ill;
    end
  end

  // Next-state selection: arbitration in IDLE, fixed walks through the sequences
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (trap_valid)      state_next = T_MEPC;
        else if (mret_valid) state_next = M_MSTATUS;
        else if (req_valid)  state_next = EXEC;
      end
      EXEC:      state_next = RESP;
      RESP:      if (rsp_ready) state_next = IDLE;
      T_MEPC:    state_next = T_MCAUSE;
      T_MCAUSE:  state_next = T_MSTATUS;
      T_MSTATUS: state_next = T_VEC;
      T_VEC:     state_next = IDLE;
      M_MSTATUS: state_next = M_VEC;
      M_VEC:     state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Per-state bank accesses, response and redirect outputs
  always_comb begin
    csr_read_id       = 12'h0;
    csr_write_request = '0;
    rsp_valid         = 1'b0;
    rsp_rdata         = 32'h0;
    rsp_illegal       = 1'b0;
    redirect_valid    = 1'b0;
    redirect_pc       = 32'h0;
    case (state)
      EXEC: begin
        csr_read_id             = id_q;
        csr_write_request.write = alu_we;
        csr_write_request.id    = id_q;
        csr_write_request.value = alu_new;
      end
      RESP: begin
        rsp_valid   = 1'b1;
        rsp_rdata   = old_q;
        rsp_illegal = illegal_q;
      end
      T_MEPC: begin
        csr_write_request.write = 1'b1;
        csr_write_request.id    = CSR_MEPC;
        csr_write_request.value = {pc_q[31:2], 2'b00};
      end
      T_MCAUSE: begin
        csr_write_request.write = 1'b1;
        csr_write_request.id    = CSR_MCAUSE;
        csr_write_request.value = cause_q;
      end
      T_MSTATUS: begin
        // Stash MIE into MPIE and disable interrupts
        csr_write_request.write           = 1'b1;
        csr_write_request.id              = CSR_MSTATUS;
        csr_write_request.value[MPIE_BIT] = mstatus.mie;
      end
      T_VEC: begin
        csr_read_id    = CSR_MTVEC;
        redirect_valid = 1'b1;
        redirect_pc    = {csr_read_value[31:2], 2'b00};
      end
      M_MSTATUS: begin
        // Restore MIE from MPIE and set MPIE
        csr_write_request.write           = 1'b1;
        csr_write_request.id              = CSR_MSTATUS;
        csr_write_request.value[MIE_BIT]  = mstatus.mpie;
        csr_write_request.value[MPIE_BIT] = 1'b1;
      end
      M_VEC: begin
        csr_read_id    = CSR_MEPC;
        redirect_valid = 1'b1;
        redirect_pc    = csr_read_value;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rv32_csr_sequencer.sv
// Bench for rv32_csr_sequencer: a behavioural CSR bank, directed vector table,
// randomized CSR instructions against a rule-level model, and hand-written
// trap / MRET / reset sequences.
module tb_rv32_csr_sequencer;
  import rv32_csr_sequencer_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               req_valid, req_ready;
  csr_op_t            req_op;
  logic [11:0]        req_csr_id;
  logic [31:0]        req_operand;
  logic               req_src_zero;
  logic               rsp_valid, rsp_ready;
  logic [31:0]        rsp_rdata;
  logic               rsp_illegal;
  logic               trap_valid, trap_ready;
  logic [31:0]        trap_cause, trap_pc;
  logic               mret_valid, mret_ready;
  logic [11:0]        csr_read_id;
  logic [31:0]        csr_read_value;
  csr_write_request_t csr_write_request;
  mstatus_t           mstatus;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;

  int checks = 0;
  int errors = 0;

  // Behavioural CSR bank with a bench-side preset port
  logic [31:0] bank [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_id = 12'h0;
  logic [31:0] pre_val = 32'h0;

  assign csr_read_value = bank[csr_read_id];

  always @(posedge clk) begin
    if (pre_we) bank[pre_id] <= pre_val;
    else if (csr_write_request.write) bank[csr_write_request.id] <= csr_write_request.value;
  end

  always #5 clk = ~clk;

  rv32_csr_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_op            (req_op),
    .req_csr_id        (req_csr_id),
    .req_operand       (req_operand),
    .req_src_zero      (req_src_zero),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rdata         (rsp_rdata),
    .rsp_illegal       (rsp_illegal),
    .trap_valid        (trap_valid),
    .trap_ready        (trap_ready),
    .trap_cause        (trap_cause),
    .trap_pc           (trap_pc),
    .mret_valid        (mret_valid),
    .mret_ready        (mret_ready),
    .csr_read_id       (csr_read_id),
    .csr_read_value    (csr_read_value),
    .csr_write_request (csr_write_request),
    .mstatus           (mstatus),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc)
  );

  typedef struct packed {
    logic [1:0]  op;
    logic [11:0] id;
    logic [31:0] operand;
    logic        sz;
    logic        preset;
    logic [31:0] init;
    logic [31:0] rdata;
    logic        ill;
    logic        we;
    logic [31:0] wval;
  } csr_vec_t;

  logic [11:0] legal_ids [10] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'hB00, 12'hB02, 12'hB80, 12'hB82};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: expected outcome of a CSR instruction from the access rules
  function automatic csr_vec_t model(input logic [1:0] op, input logic [11:0] id,
                                     input logic [31:0] opnd, input logic sz,
                                     input logic [31:0] old);
    csr_vec_t v;
    bit legal, try_wr;
    legal = 0;
    foreach (legal_ids[i]) if (legal_ids[i] == id) legal = 1;
    try_wr = (op == 2'd0) || !sz;
    v = '0;
    v.op = op; v.id = id; v.operand = opnd; v.sz = sz;
    v.preset = 1'b1; v.init = old;
    v.ill = !legal || (try_wr && id[11:10] == 2'b11);
    v.we = try_wr && !v.ill;
    case (op)
      2'd0:    v.wval = opnd;
      2'd1:    v.wval = old | opnd;
      default: v.wval = old & ~opnd;
    endcase
    v.rdata = v.ill ? 32'h0 : old;
    return v;
  endfunction

  task automatic preset(input logic [11:0] id, input logic [31:0] val);
    @(negedge clk);
    pre_we = 1'b1; pre_id = id; pre_val = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic run_csr(input csr_vec_t v, input string tag);
    if (v.preset) preset(v.id, v.init);
    @(negedge clk);
    req_valid = 1'b1; req_op = csr_op_t'(v.op); req_csr_id = v.id;
    req_operand = v.operand; req_src_zero = v.sz;
    #1;
    chk({tag, " req_ready"}, 64'(req_ready), 64'(1'b1));
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, " exec_write"}, 64'(csr_write_request.write), 64'(v.we));
    if (v.we) chk({tag, " exec_wreq"}, 64'(csr_write_request), 64'({1'b1, v.id, v.wval}));
    chk({tag, " exec_read_id"}, 64'(csr_read_id), 64'(v.id));
    chk({tag, " early_rsp"}, 64'(rsp_valid), 64'(1'b0));
    @(negedge clk);
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(1'b1));
    chk({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(v.rdata));
    chk({tag, " rsp_illegal"}, 64'(rsp_illegal), 64'(v.ill));
    chk({tag, " resp_write"}, 64'(csr_write_request.write), 64'(1'b0));
    @(negedge clk);
    chk({tag, " rsp_hold"}, 64'({rsp_valid, rsp_rdata}), 64'({1'b1, v.rdata}));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, " rsp_done"}, 64'({rsp_valid, req_ready}), 64'({1'b0, 1'b1}));
  endtask

  // Returns at the negedge of the redirect cycle
  task automatic trap_seq(input logic [31:0] cause, input logic [31:0] pc,
                          input logic mie_in, input logic [31:0] mtvec_v, input string tag);
    preset(CSR_MTVEC, mtvec_v);
    @(negedge clk);
    trap_valid = 1'b1; trap_cause = cause; trap_pc = pc; mstatus.mie = mie_in;
    #1;
    chk({tag, " trap_ready"}, 64'(trap_ready), 64'(1'b1));
    if (mret_valid) chk({tag, " mret_blocked"}, 64'(mret_ready), 64'(1'b0));
    if (req_valid)  chk({tag, " req_blocked"}, 64'(req_ready), 64'(1'b0));
    @(negedge clk);
    trap_valid = 1'b0; req_valid = 1'b0;
    chk({tag, " wr_mepc"}, 64'(csr_write_request), 64'({1'b1, CSR_MEPC, pc[31:2], 2'b00}));
    chk({tag, " no_early_redirect"}, 64'(redirect_valid), 64'(1'b0));
    @(negedge clk);
    chk({tag, " wr_mcause"}, 64'(csr_write_request), 64'({1'b1, CSR_MCAUSE, cause}));
    @(negedge clk);
    chk({tag, " wr_mstatus"}, 64'(csr_write_request),
        64'({1'b1, CSR_MSTATUS, 24'h0, mie_in, 7'h0}));
    @(negedge clk);
    chk({tag, " vec_nowrite"}, 64'(csr_write_request.write), 64'(1'b0));
    chk({tag, " vec_read_id"}, 64'(csr_read_id), 64'(CSR_MTVEC));
    chk({tag, " redirect"}, 64'({redirect_valid, redirect_pc}),
        64'({1'b1, mtvec_v[31:2], 2'b00}));
  endtask

  task automatic mret_seq(input logic mpie_in, input logic [31:0] exp_mepc, input string tag);
    @(negedge clk);
    chk({tag, " pulse_end"}, 64'(redirect_valid), 64'(1'b0));
    mret_valid = 1'b1; mstatus.mpie = mpie_in; mstatus.mie = 1'b0;
    #1;
    chk({tag, " mret_ready"}, 64'(mret_ready), 64'(1'b1));
    @(negedge clk);
    mret_valid = 1'b0;
    chk({tag, " wr_mstatus"}, 64'(csr_write_request),
        64'({1'b1, CSR_MSTATUS, 24'h0, 1'b1, 3'b000, mpie_in, 3'b000}));
    @(negedge clk);
    chk({tag, " read_mepc"}, 64'(csr_read_id), 64'(CSR_MEPC));
    chk({tag, " redirect"}, 64'({redirect_valid, redirect_pc}), 64'({1'b1, exp_mepc}));
    @(negedge clk);
    chk({tag, " back_idle"}, 64'({redirect_valid, trap_ready}), 64'({1'b0, 1'b1}));
  endtask

  csr_vec_t vecs [10];

  initial begin
    csr_vec_t v;
    logic [1:0]  r_op;
    logic [11:0] r_id;
    logic        r_sz;
    logic [31:0] r_opnd;
    int          seen_wr, seen_rd;

    reset = 1'b1;
    req_valid = 1'b0; req_op = CSR_RW; req_csr_id = 12'h0; req_operand = 32'h0;
    req_src_zero = 1'b0; rsp_ready = 1'b0; trap_valid = 1'b0; trap_cause = 32'h0;
    trap_pc = 32'h0; mret_valid = 1'b0; mstatus = '0;

    //            op     id       operand       sz  pre   init          rdata         ill we  wval
    vecs[0] = {2'd0, 12'h340, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[1] = {2'd1, 12'h340, 32'h0,        1'b1, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[2] = {2'd1, 12'h305, 32'h0,        1'b1, 1'b1, 32'h100,      32'h100,      1'b0, 1'b0, 32'h0};
    vecs[3] = {2'd1, 12'h305, 32'h3,        1'b0, 1'b0, 32'h0,        32'h100,      1'b0, 1'b1, 32'h103};
    vecs[4] = {2'd2, 12'h7C0, 32'hFF,       1'b0, 1'b1, 32'h55,       32'h0,        1'b1, 1'b0, 32'h0};
    vecs[5] = {2'd2, 12'h342, 32'h0F,       1'b0, 1'b1, 32'hFF,       32'hFF,       1'b0, 1'b1, 32'hF0};
    vecs[6] = {2'd0, 12'hB00, 32'h12345678, 1'b1, 1'b1, 32'hAAAA,     32'hAAAA,     1'b0, 1'b1, 32'h12345678};
    vecs[7] = {2'd1, 12'hC00, 32'h0,        1'b1, 1'b1, 32'h77,       32'h0,        1'b1, 1'b0, 32'h0};
    vecs[8] = {2'd2, 12'hB82, 32'hFFFF0000, 1'b0, 1'b1, 32'h1234FFFF, 32'h1234FFFF, 1'b0, 1'b1, 32'h0000FFFF};
    vecs[9] = {2'd2, 12'h304, 32'h0,        1'b1, 1'b1, 32'h888,      32'h888,      1'b0, 1'b0, 32'h0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset readies", 64'({req_ready, trap_ready, mret_ready}), 64'(3'b000));
    chk("reset wreq", 64'(csr_write_request), 64'(0));
    chk("reset rsp", 64'({rsp_valid, rsp_illegal, rsp_rdata}), 64'(0));
    chk("reset redirect", 64'({redirect_valid, redirect_pc, csr_read_id}), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle after reset", 64'({req_ready, trap_ready, mret_ready}), 64'(3'b111));

    // Directed vector table
    for (int i = 0; i < 10; i++) run_csr(vecs[i], $sformatf("vec%0d", i));

    // Randomized CSR instructions against the rule model
    for (int i = 0; i < 40; i++) begin
      r_op   = 2'($urandom_range(0, 2));
      r_id   = ($urandom_range(0, 3) < 3) ? legal_ids[$urandom_range(0, 9)]
                                          : 12'($urandom_range(0, 4095));
      r_sz   = 1'($urandom_range(0, 1));
      r_opnd = r_sz ? 32'h0 : $urandom();
      v = model(r_op, r_id, r_opnd, r_sz, $urandom());
      run_csr(v, $sformatf("rnd%0d", i));
    end

    // Trap entry, aligned PC, interrupts enabled
    trap_seq(32'h8000000B, 32'h1234, 1'b1, 32'h80, "trap1");
    // Trap with misaligned PC and vector, interrupts disabled
    trap_seq(32'h2, 32'h1237, 1'b0, 32'h203, "trap2");
    mret_seq(1'b0, 32'h1234, "mret_solo");

    // Simultaneous trap, mret and request: trap wins, mret follows
    req_op = CSR_RW; req_csr_id = 12'h340; req_operand = 32'h5;
    req_src_zero = 1'b0; req_valid = 1'b1; mret_valid = 1'b1;
    trap_seq(32'h8000000B, 32'h1234, 1'b1, 32'h80, "arb_trap");
    mret_seq(1'b1, 32'h1234, "arb_mret");

    // Reset in the middle of a trap sequence
    preset(CSR_MTVEC, 32'h80);
    @(negedge clk);
    trap_valid = 1'b1; trap_cause = 32'h7; trap_pc = 32'h4000;
    @(negedge clk);
    trap_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid in mcause", 64'(csr_write_request), 64'({1'b1, CSR_MCAUSE, 32'h7}));
    reset = 1'b1;
    #1;
    chk("rst_mid wreq", 64'(csr_write_request), 64'(0));
    chk("rst_mid outs", 64'({redirect_valid, rsp_valid, trap_ready, mret_ready, req_ready, csr_read_id}),
        64'(0));
    @(negedge clk);
    reset = 1'b0;
    seen_wr = 0; seen_rd = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (csr_write_request.write) seen_wr++;
      if (redirect_valid) seen_rd++;
    end
    chk("rst_mid no writes", 64'(seen_wr), 64'(0));
    chk("rst_mid no redirect", 64'(seen_rd), 64'(0));
    chk("rst_mid idle", 64'(trap_ready), 64'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
